serial_adder: RTL and testbench

// - Bit-serial ripple adder: adds two WIDTH-bit operands plus carry-in, LSB first, one bit per clock.
// - Full-adder counterpart of the team's full-subtractor cell.
// - Feeds area-constrained datapaths where one adder cell is reused over WIDTH cycles.
// - start/busy/done handshake. Result held stable until the next accepted start.

---
 rtl/serial_arith_pkg.sv | 12 +
 rtl/full_adder_cell.sv | 14 +
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared constants for the bit-serial arithmetic cells: FSM encoding and default width.
package serial_arith_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

endpackage : serial_arith_pkg

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder; the single arithmetic cell reused every cycle
// by the serial adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_cell

// File: rtl/serial_adder.sv
// Bit-serial adder: (a + b + cin) computed LSB first over WIDTH cycles through one
// full-adder cell, with registered sum, unsigned carry-out and signed overflow.
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: start is taken on a rising edge only when busy==0 (IDLE or DONE);
  // a, b, cin are sampled on that edge alone. busy is high for exactly WIDTH
  // cycles, then done pulses for one cycle while sum/cout/ovf hold the new result.

  state_t            state;
  state_t            next_state;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic [WIDTH-1:0]  res_sh;
  logic [WIDTH-1:0]  res_next;
  logic              carry;
  logic [CW-1:0]     cnt;
  logic              fa_s;
  logic              fa_cout;
  logic              accept;
  logic              last_step;

  full_adder_cell u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign accept    = start && (state != S_RUN);
  assign last_step = (cnt == CW'(WIDTH - 1));

  // New sum bit enters at the MSB so the LSB-first stream ends up in place.
  always_comb begin
    res_next            = res_sh >> 1;
    res_next[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_RUN;
      S_RUN:   if (last_step) next_state = S_DONE;
      S_DONE:  next_state = start ? S_RUN : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      res_sh <= '0;
      carry  <= cin;
      cnt    <= '0;
    end else if (state == S_RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_next;
      carry  <= fa_cout;
      // Counter parks on its final value so it never exceeds WIDTH-1.
      cnt    <= last_step ? cnt : cnt + CW'(1);
      if (last_step) begin
        sum  <= res_next;
        cout <= fa_cout;
        ovf  <= carry ^ fa_cout;
      end
    end
  end

  always_comb begin
    busy      = (state == S_RUN);
    done      = (state == S_DONE);
    dbg_state = state;
  end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed and random operands compared
// against an arithmetic reference model, plus handshake and reset scenarios.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [1:0]   dbg_state;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_res;
  int           n_checks;
  int           n_errors;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, cout, sum} from plain unsigned and signed arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc);
    int unsigned u;
    int          s;
    logic [W-1:0] r;
    logic        co;
    logic        ov;
    u  = int'(ma) + int'(mb) + int'(mc);
    s  = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
    r  = W'(u % (1 << W));
    co = (u >= (1 << W));
    ov = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
    return {ov, co, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input bit poke_mid);
    int           busy_cnt;
    bit           got_done;
    logic [W+1:0] e;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    exp_q.push_back(model(ta, tb_v, tc));
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    busy_cnt = 0;
    got_done = 0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      if (done) begin
        got_done = 1;
      end else begin
        if (busy) busy_cnt++;
        check("sum_stable", {ovf, cout, sum}, last_res);
        start = (poke_mid && busy_cnt == 3);
        if (start) begin
          a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    check("done_seen", got_done, 1);
    check("busy_cycles", busy_cnt, W);
    e = exp_q.pop_front();
    if (got_done) begin
      check("busy_at_done", busy, 0);
      check("result", {ovf, cout, sum}, e);
      last_res = e;
    end
    @(negedge clk);
    check("done_pulse", done, 0);
    if (poke_mid) begin
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        check("no_second_done", done, 0);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    last_res = '0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", {ovf, cout, sum}, 0);
    rst_n = 1'b1;

    run_op(8'h3C, 8'h05, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b1, 0);
    run_op(8'h7F, 8'h01, 1'b0, 0);
    run_op(8'h80, 8'h80, 1'b0, 0);
    run_op(8'h12, 8'h34, 1'b1, 1);

    for (int k = 0; k < 20; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0);
    end

    // start held high: a new result every W+1 cycles, operands taken at each accept
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("hold_done", done, (i % (W + 1) == 0));
        if (done) begin
          if (exp_q.size() > 0) begin
            last_res = exp_q.pop_front();
            check("hold_result", {ovf, cout, sum}, last_res);
          end else begin
            check("hold_queue", 0, 1);
          end
        end
      end
      if (i < 4 * (W + 1)) begin
        start = 1'b1;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        if (i % (W + 1) == 0) exp_q.push_back(model(a, b, cin));
      end else begin
        start = 1'b0;
      end
    end
    check("hold_queue_empty", exp_q.size(), 0);

    // Reset while the fourth bit is being processed
    @(negedge clk);
    a = 8'hA5; b = 8'h5A; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", {ovf, cout, sum}, 0);
    rst_n = 1'b1;
    last_res = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_rst_no_done", done, 0);
    end
    run_op(8'h01, 8'h01, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_serial_adder
